// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and helpers for the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int FWD_NONE         = 0;
    localparam int DEF_NUM_FWD      = 2;
    localparam int DEF_LOP_DEPTH    = 2;
    localparam int DEF_FLUSH_CYCLES = 1;

    // Width of a forward select able to encode "none" plus one code per stage.
    function automatic int fwd_sel_w(input int num_fwd);
        return (num_fwd < 1) ? 1 : $clog2(num_fwd + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_lop_tracker.sv
`default_nettype none
// ============================================================================
// Module      : hazard_lop_tracker
// Description : Pending-register vector and outstanding counter for long ops.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_lop_tracker #(
    parameter int LOP_DEPTH = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lop_issue_i,
    input  logic [4:0] lop_rd_i,
    input  logic       lop_done_i,
    input  logic [4:0] lop_done_rd_i,
    input  logic [4:0] rs1D_i,
    input  logic [4:0] rs2D_i,
    input  logic       rs1_used_i,
    input  logic       rs2_used_i,
    output logic       sb_hit_o,
    output logic       struct_stall_o,
    output logic       sb_err_o
);

    localparam int             CW     = $clog2(LOP_DEPTH + 1);
    localparam logic [CW-1:0]  c_full = CW'(LOP_DEPTH);

    logic [31:0]   r_pending;
    logic [CW-1:0] r_outstanding;
    logic          r_err;

    logic          w_full;
    logic          w_issue_ok;
    logic          w_done_ok;
    logic [1:0][4:0] w_src;
    logic [1:0]    w_used;

    assign w_full         = (r_outstanding == c_full);
    assign w_issue_ok     = lop_issue_i && (lop_rd_i != 5'd0) && !w_full;
    assign w_done_ok      = lop_done_i && (r_outstanding != '0) && r_pending[lop_done_rd_i];
    assign struct_stall_o = lop_issue_i && w_full;
    assign sb_err_o       = r_err;

    assign w_src  = {rs2D_i, rs1D_i};
    assign w_used = {rs2_used_i, rs1_used_i};

    // A register retiring this cycle no longer blocks; one issuing this cycle already does.
    always_comb begin
        sb_hit_o = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (w_used[s] && (w_src[s] != 5'd0) &&
                ((r_pending[w_src[s]] && !(w_done_ok && (lop_done_rd_i == w_src[s]))) ||
                 (lop_issue_i && (lop_rd_i == w_src[s])))) begin
                sb_hit_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            // Clear before set so a same-register issue keeps the bit.
            r_pending <= (r_pending & ~(w_done_ok  ? (32'd1 << lop_done_rd_i) : 32'd0))
                                    |  (w_issue_ok ? (32'd1 << lop_rd_i)      : 32'd0);
            case ({w_issue_ok, w_done_ok})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (lop_done_i && !w_done_ok) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Forwarding, load-use, long-op scoreboard and flush control.
//               HAZARD_SCOREBOARD_PERF_EN enables the stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import riscv_pkg::*;
#(
    parameter int NUM_FWD      = DEF_NUM_FWD,
    parameter int LOP_DEPTH    = DEF_LOP_DEPTH,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [4:0]                        rs1D_i,
    input  logic [4:0]                        rs2D_i,
    input  logic                              rs1_used_i,
    input  logic                              rs2_used_i,
    input  logic [NUM_FWD-1:0][4:0]           rd_fwd_i,
    input  logic [NUM_FWD-1:0]                wr_ena_fwd_i,
    input  logic                              load_e_i,
    input  logic                              lop_issue_i,
    input  logic [4:0]                        lop_rd_i,
    input  logic                              lop_done_i,
    input  logic [4:0]                        lop_done_rd_i,
    input  logic                              branch_tkn_i,
    output logic                              stall_o,
    output logic                              pc_en_o,
    output logic                              flush_o,
    output logic [fwd_sel_w(NUM_FWD)-1:0]     forwardA_o,
    output logic [fwd_sel_w(NUM_FWD)-1:0]     forwardB_o,
    output logic                              sb_err_o,
    output logic [31:0]                       stall_cnt_o,
    output logic [31:0]                       flush_cnt_o
);

    localparam int             FW          = fwd_sel_w(NUM_FWD);
    localparam int             FCW         = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FCW-1:0] c_flush_len = FCW'(FLUSH_CYCLES);

    logic           w_load_use;
    logic           w_sb_hit;
    logic           w_struct;
    logic [FCW-1:0] r_flush_cnt;

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        forwardA_o = FW'(FWD_NONE);
        forwardB_o = FW'(FWD_NONE);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (wr_ena_fwd_i[k] && (rd_fwd_i[k] != 5'd0)) begin
                if (rs1_used_i && (rs1D_i == rd_fwd_i[k])) forwardA_o = FW'(k + 1);
                if (rs2_used_i && (rs2D_i == rd_fwd_i[k])) forwardB_o = FW'(k + 1);
            end
        end
    end

    assign w_load_use = load_e_i && wr_ena_fwd_i[0] && (rd_fwd_i[0] != 5'd0) &&
                        ((rs1_used_i && (rs1D_i == rd_fwd_i[0])) ||
                         (rs2_used_i && (rs2D_i == rd_fwd_i[0])));

    hazard_lop_tracker #(
        .LOP_DEPTH      (LOP_DEPTH)
    ) u_lop_tracker (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lop_issue_i    (lop_issue_i),
        .lop_rd_i       (lop_rd_i),
        .lop_done_i     (lop_done_i),
        .lop_done_rd_i  (lop_done_rd_i),
        .rs1D_i         (rs1D_i),
        .rs2D_i         (rs2D_i),
        .rs1_used_i     (rs1_used_i),
        .rs2_used_i     (rs2_used_i),
        .sb_hit_o       (w_sb_hit),
        .struct_stall_o (w_struct),
        .sb_err_o       (sb_err_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flush_cnt <= '0;
        end else if (branch_tkn_i) begin
            r_flush_cnt <= c_flush_len;
        end else if (r_flush_cnt != '0) begin
            r_flush_cnt <= r_flush_cnt - FCW'(1);
        end
    end

    assign flush_o = (r_flush_cnt != '0) || branch_tkn_i;
    assign stall_o = (w_load_use || w_sb_hit || w_struct) && !flush_o;
    assign pc_en_o = !stall_o;

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_evt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_evt <= '0;
        end else begin
            if (stall_o)      r_stall_cnt <= r_stall_cnt + 32'd1;
            if (branch_tkn_i) r_flush_evt <= r_flush_evt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_evt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Vector table, directed corner sequences and random stimulus
//               against a behavioural model of the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NUM_FWD      = 2;
    localparam int LOP_DEPTH    = 2;
    localparam int FLUSH_CYCLES = 2;
    localparam int FW           = $clog2(NUM_FWD + 1);
`ifdef HAZARD_SCOREBOARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs1, rs2, lop_rd, done_rd;
    logic u1, u2, load, lop_issue, lop_done, branch;
    logic [NUM_FWD-1:0][4:0] rd_fwd;
    logic [NUM_FWD-1:0] we;
    logic stall, pc_en, flush, sb_err;
    logic [FW-1:0] fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    // Model state: set of pending registers, outstanding count, flush cycles left.
    bit          m_pend [32];
    int          m_cnt;
    bit          m_err;
    int          m_fl;
    int unsigned m_sc, m_fc;

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd0, rd1;
        logic [1:0] we;
        logic       load;
        int         exp_a, exp_b;
        logic       exp_stall;
    } vec_t;
    vec_t tbl [10];

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_FWD       (NUM_FWD),
        .LOP_DEPTH     (LOP_DEPTH),
        .FLUSH_CYCLES  (FLUSH_CYCLES)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rs1D_i        (rs1),
        .rs2D_i        (rs2),
        .rs1_used_i    (u1),
        .rs2_used_i    (u2),
        .rd_fwd_i      (rd_fwd),
        .wr_ena_fwd_i  (we),
        .load_e_i      (load),
        .lop_issue_i   (lop_issue),
        .lop_rd_i      (lop_rd),
        .lop_done_i    (lop_done),
        .lop_done_rd_i (done_rd),
        .branch_tkn_i  (branch),
        .stall_o       (stall),
        .pc_en_o       (pc_en),
        .flush_o       (flush),
        .forwardA_o    (fwd_a),
        .forwardB_o    (fwd_b),
        .sb_err_o      (sb_err),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_done_valid();
        return lop_done && (m_cnt > 0) && m_pend[done_rd];
    endfunction

    function automatic int exp_fwd(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 0;
        for (int k = 0; k < NUM_FWD; k++)
            if (we[k] && rd_fwd[k] == rs) return k + 1;
        return 0;
    endfunction

    function automatic bit exp_sb(input logic [4:0] rs, input logic used);
        if (!used || rs == 5'd0) return 1'b0;
        if (lop_issue && lop_rd == rs) return 1'b1;
        return m_pend[rs] && !(m_done_valid() && done_rd == rs);
    endfunction

    function automatic bit exp_load_use();
        if (!(load && we[0] && rd_fwd[0] != 5'd0)) return 1'b0;
        return (u1 && rs1 == rd_fwd[0]) || (u2 && rs2 == rd_fwd[0]);
    endfunction

    function automatic bit exp_flush();
        return (m_fl > 0) || branch;
    endfunction

    function automatic bit exp_stall();
        bit any;
        any = exp_load_use() || exp_sb(rs1, u1) || exp_sb(rs2, u2) ||
              (lop_issue && m_cnt == LOP_DEPTH);
        return any && !exp_flush();
    endfunction

    task automatic m_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_cnt = 0; m_err = 1'b0; m_fl = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic zero_in();
        rs1 = '0; rs2 = '0; u1 = 1'b0; u2 = 1'b0; rd_fwd = '0; we = '0;
        load = 1'b0; lop_issue = 1'b0; lop_rd = '0; lop_done = 1'b0;
        done_rd = '0; branch = 1'b0;
    endtask

    // Called at posedge+1 with inputs driven; compares at posedge+2.
    task automatic model_check();
        bit st;
        #1;
        st = exp_stall();
        chk("stall_o",     32'(stall),  32'(st));
        chk("pc_en_o",     32'(pc_en),  32'(!st));
        chk("flush_o",     32'(flush),  32'(exp_flush()));
        chk("forwardA_o",  32'(fwd_a),  32'(exp_fwd(rs1, u1)));
        chk("forwardB_o",  32'(fwd_b),  32'(exp_fwd(rs2, u2)));
        chk("sb_err_o",    32'(sb_err), 32'(m_err));
        chk("stall_cnt_o", stall_cnt,   PERF ? m_sc : 32'd0);
        chk("flush_cnt_o", flush_cnt,   PERF ? m_fc : 32'd0);
    endtask

    task automatic tick();
        bit dv, iv, st;
        dv = m_done_valid();
        iv = lop_issue && lop_rd != 5'd0 && m_cnt < LOP_DEPTH;
        st = exp_stall();
        if (st) m_sc++;
        if (branch) m_fc++;
        if (lop_done && !dv) m_err = 1'b1;
        if (dv) begin m_pend[done_rd] = 1'b0; m_cnt--; end
        if (iv) begin m_pend[lop_rd] = 1'b1; m_cnt++; end
        if (branch) m_fl = FLUSH_CYCLES;
        else if (m_fl > 0) m_fl--;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        model_check();
        tick();
    endtask

    task automatic do_reset();
        zero_in();
        rst = 1'b1;
        #1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        //            rs1 rs2 u1 u2 rd0 rd1 we     ld  A  B  stall
        tbl[0] = '{5'd5, 5'd0, 1, 0, 5'd5, 5'd5, 2'b11, 0, 1, 0, 0};
        tbl[1] = '{5'd5, 5'd0, 1, 0, 5'd5, 5'd5, 2'b10, 0, 2, 0, 0};
        tbl[2] = '{5'd5, 5'd0, 0, 0, 5'd5, 5'd5, 2'b11, 0, 0, 0, 0};
        tbl[3] = '{5'd0, 5'd0, 1, 1, 5'd0, 5'd0, 2'b11, 0, 0, 0, 0};
        tbl[4] = '{5'd0, 5'd7, 0, 1, 5'd7, 5'd0, 2'b01, 1, 0, 1, 1};
        tbl[5] = '{5'd0, 5'd7, 0, 1, 5'd0, 5'd0, 2'b01, 1, 0, 0, 0};
        tbl[6] = '{5'd0, 5'd7, 0, 1, 5'd7, 5'd0, 2'b00, 1, 0, 0, 0};
        tbl[7] = '{5'd7, 5'd7, 1, 1, 5'd7, 5'd0, 2'b01, 1, 1, 1, 1};
        tbl[8] = '{5'd3, 5'd4, 1, 1, 5'd4, 5'd3, 2'b11, 0, 2, 1, 0};
        tbl[9] = '{5'd0, 5'd7, 0, 0, 5'd7, 5'd0, 2'b01, 1, 0, 0, 0};

        zero_in();
        m_reset();
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pc_en", 32'(pc_en), 32'd1);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_fwdA",  32'(fwd_a), 32'd0);
        chk("rst_fwdB",  32'(fwd_b), 32'd0);
        chk("rst_err",   32'(sb_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            rs1 = tbl[i].rs1; rs2 = tbl[i].rs2; u1 = tbl[i].u1; u2 = tbl[i].u2;
            rd_fwd[0] = tbl[i].rd0; rd_fwd[1] = tbl[i].rd1; we = tbl[i].we; load = tbl[i].load;
            model_check();
            chk($sformatf("tbl%0d_fwdA", i),  32'(fwd_a), 32'(tbl[i].exp_a));
            chk($sformatf("tbl%0d_fwdB", i),  32'(fwd_b), 32'(tbl[i].exp_b));
            chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].exp_stall));
            tick();
        end

        // Long op on x9 blocks decode until its writeback cycle.
        do_reset();
        lop_issue = 1'b1; lop_rd = 5'd9; cycle();
        lop_issue = 1'b0; rs1 = 5'd9; u1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_check(); chk("sb_wait_stall", 32'(stall), 32'd1); tick();
        end
        lop_done = 1'b1; done_rd = 5'd9;
        model_check(); chk("sb_done_stall", 32'(stall), 32'd0); tick();
        lop_done = 1'b0;
        model_check(); chk("sb_after_stall", 32'(stall), 32'd0); tick();

        // Structural limit, then an unmatched completion.
        do_reset();
        lop_issue = 1'b1; lop_rd = 5'd3; cycle();
        lop_rd = 5'd4; cycle();
        lop_rd = 5'd5;
        model_check(); chk("struct_stall", 32'(stall), 32'd1); tick();
        model_check(); chk("struct_still_full", 32'(stall), 32'd1); tick();
        lop_issue = 1'b0; lop_done = 1'b1; done_rd = 5'd6;
        model_check(); chk("err_before", 32'(sb_err), 32'd0); tick();
        lop_done = 1'b0;
        model_check(); chk("err_sticky", 32'(sb_err), 32'd1); tick();
        lop_done = 1'b1; done_rd = 5'd3; cycle();
        lop_done = 1'b0; lop_issue = 1'b1; lop_rd = 5'd5;
        model_check(); chk("struct_freed", 32'(stall), 32'd0); tick();

        // Flush overrides a load-use hit; a second branch extends it.
        do_reset();
        load = 1'b1; we = 2'b01; rd_fwd[0] = 5'd7; rs2 = 5'd7; u2 = 1'b1; branch = 1'b1;
        model_check(); chk("fl0_flush", 32'(flush), 32'd1); chk("fl0_stall", 32'(stall), 32'd0); tick();
        branch = 1'b0;
        model_check(); chk("fl1_flush", 32'(flush), 32'd1); chk("fl1_stall", 32'(stall), 32'd0); tick();
        branch = 1'b1;
        model_check(); chk("fl2_flush", 32'(flush), 32'd1); tick();
        branch = 1'b0;
        model_check(); chk("fl3_flush", 32'(flush), 32'd1); tick();
        model_check(); chk("fl4_flush", 32'(flush), 32'd1); tick();
        model_check(); chk("fl5_flush", 32'(flush), 32'd0); chk("fl5_stall", 32'(stall), 32'd1); tick();

        // Reset mid-flush with two long ops outstanding.
        do_reset();
        lop_issue = 1'b1; lop_rd = 5'd3; cycle();
        lop_rd = 5'd4; cycle();
        lop_issue = 1'b0; branch = 1'b1; cycle();
        branch = 1'b0;
        model_check(); chk("pre_rst_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_flush", 32'(flush), 32'd0);
        chk("midrst_stall_cnt", stall_cnt, 32'd0);
        chk("midrst_flush_cnt", flush_cnt, 32'd0);
        chk("midrst_err", 32'(sb_err), 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        lop_issue = 1'b1; lop_rd = 5'd5;
        model_check(); chk("post_rst_issue", 32'(stall), 32'd0); tick();
        lop_issue = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if (n % 150 == 0) do_reset();
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            u1 = 1'($urandom); u2 = 1'($urandom);
            for (int k = 0; k < NUM_FWD; k++) rd_fwd[k] = 5'($urandom_range(0, 7));
            we = NUM_FWD'($urandom);
            load      = ($urandom_range(0, 3) == 0);
            lop_issue = ($urandom_range(0, 2) == 0);
            lop_rd    = 5'($urandom_range(0, 7));
            lop_done  = ($urandom_range(0, 2) == 0);
            done_rd   = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                for (int r = 1; r < 32; r++) begin
                    if (m_pend[r]) begin
                        done_rd = 5'(r);
                        break;
                    end
                end
            end
            branch = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
